// File: rtl/rtc_upd4990.sv
// uPD4990A-style serial calendar/RTC: BCD time keeping, 4-bit serial
// commands, 1 Hz / serial DOUT and TP square-wave or interval output.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   nRESET     synchronous active-low reset
//   RTC_CLK    serial shift clock (asynchronous)
//   RTC_DIN    serial data in (asynchronous)
//   RTC_STROBE command strobe (asynchronous)
//   RTC_DOUT   serial data out / 1 Hz square wave
//   RTC_TP     timing pulse output
//   SEC_TICK   one-clk pulse after each second rollover
module rtc_upd4990 #(
    parameter int          CLK_DIV   = 2930,
    parameter logic [39:0] INIT_TIME = 40'h1_0_01_00_00_00
) (
    input  logic clk,
    input  logic nRESET,
    input  logic RTC_CLK,
    input  logic RTC_DIN,
    input  logic RTC_STROBE,
    output logic RTC_DOUT,
    output logic RTC_TP,
    output logic SEC_TICK
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [3:0] CMD_SHIFT = 4'h1;
    localparam logic [3:0] CMD_SET   = 4'h2;
    localparam logic [3:0] CMD_READ  = 4'h3;
    localparam logic [3:0] CMD_IVCLR = 4'hC;
    localparam logic [3:0] CMD_IVRUN = 4'hD;
    localparam logic [3:0] CMD_IVSTP = 4'hE;

    logic          r_clk_s1, r_clk_s2, r_clk_s3;
    logic          r_stb_s1, r_stb_s2, r_stb_s3;
    logic          r_din_s1, r_din_s2;
    logic [DW-1:0] r_div;
    logic [12:0]   r_presc;
    logic          r_sec_tick;
    logic [39:0]   r_time;
    logic [39:0]   r_shift_sr;
    logic [3:0]    r_cmd_sr;
    logic [3:0]    r_cmd;
    logic          r_iv_mode;
    logic [1:0]    r_tp_sel;
    logic [1:0]    r_iv_n;
    logic          r_iv_run;
    logic [5:0]    r_iv_cnt;
    logic [7:0]    r_pulse;

    logic          w_clk_rise;
    logic          w_stb_rise;
    logic          w_shift;
    logic          w_base;
    logic          w_sec;
    logic [5:0]    w_n;
    logic          w_sq;
    logic          w_iv_hit;

    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] f_mlen(input logic [3:0] mo);
        logic [7:0] r;
        case (mo)
            4'd2:                    r = 8'h29;
            4'd4, 4'd6, 4'd9, 4'd11: r = 8'h30;
            default:                 r = 8'h31;
        endcase
        return r;
    endfunction

    // One-second advance of the packed BCD calendar with carry chain.
    function automatic logic [39:0] f_next(input logic [39:0] t);
        logic [7:0] sec, mn, hr, dy;
        logic [3:0] wd, mo;
        logic       c;
        sec = t[7:0];
        mn  = t[15:8];
        hr  = t[23:16];
        dy  = t[31:24];
        wd  = t[35:32];
        mo  = t[39:36];
        c   = (sec >= 8'h59);
        sec = c ? 8'h00 : f_bcd_inc(sec);
        if (c) begin
            c  = (mn >= 8'h59);
            mn = c ? 8'h00 : f_bcd_inc(mn);
        end
        if (c) begin
            c  = (hr >= 8'h23);
            hr = c ? 8'h00 : f_bcd_inc(hr);
        end
        if (c) begin
            wd = (wd >= 4'd6) ? 4'd0 : wd + 4'd1;
            c  = (dy >= f_mlen(mo));
            dy = c ? 8'h01 : f_bcd_inc(dy);
        end
        if (c) mo = (mo >= 4'd12) ? 4'd1 : mo + 4'd1;
        return {mo, wd, dy, hr, mn, sec};
    endfunction

    assign w_clk_rise = r_clk_s2 & ~r_clk_s3;
    assign w_stb_rise = r_stb_s2 & ~r_stb_s3;
    // A strobe rise implies synced STROBE high, so it also blocks the shift.
    assign w_shift    = w_clk_rise & ~r_stb_s2;
    assign w_base     = (r_div == DIV_LAST);
    assign w_sec      = w_base & (r_presc == 13'h1FFF);
    assign w_iv_hit   = ({1'b0, r_iv_cnt} + 7'd1) >= {1'b0, w_n};

    always_comb begin
        w_n = 6'd60;
        case (r_iv_n)
            2'd0:    w_n = 6'd1;
            2'd1:    w_n = 6'd10;
            2'd2:    w_n = 6'd30;
            default: w_n = 6'd60;
        endcase
    end

    always_comb begin
        w_sq = r_presc[6];
        case (r_tp_sel)
            2'd0:    w_sq = r_presc[6];
            2'd1:    w_sq = r_presc[4];
            2'd2:    w_sq = r_presc[1];
            default: w_sq = r_presc[0];
        endcase
    end

    always_comb begin
        RTC_DOUT = r_presc[12];
        case (r_cmd)
            CMD_SHIFT, CMD_SET, CMD_READ: RTC_DOUT = r_shift_sr[0];
            default:                      RTC_DOUT = r_presc[12];
        endcase
    end

    // Square wave is inverted so TP idles high right after reset.
    assign RTC_TP   = r_iv_mode ? (r_pulse == 8'd0) : ~w_sq;
    assign SEC_TICK = r_sec_tick;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_s3   <= 1'b0;
            r_stb_s1   <= 1'b0;
            r_stb_s2   <= 1'b0;
            r_stb_s3   <= 1'b0;
            r_din_s1   <= 1'b0;
            r_din_s2   <= 1'b0;
            r_div      <= '0;
            r_presc    <= 13'd0;
            r_sec_tick <= 1'b0;
            r_time     <= INIT_TIME;
            r_shift_sr <= 40'd0;
            r_cmd_sr   <= 4'd0;
            r_cmd      <= 4'd0;
            r_iv_mode  <= 1'b0;
            r_tp_sel   <= 2'd0;
            r_iv_n     <= 2'd0;
            r_iv_run   <= 1'b0;
            r_iv_cnt   <= 6'd0;
            r_pulse    <= 8'd0;
        end else begin
            r_clk_s1 <= RTC_CLK;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_stb_s1 <= RTC_STROBE;
            r_stb_s2 <= r_stb_s1;
            r_stb_s3 <= r_stb_s2;
            r_din_s1 <= RTC_DIN;
            r_din_s2 <= r_din_s1;

            r_div <= w_base ? '0 : r_div + DW'(1);
            if (w_base) r_presc <= r_presc + 13'd1;
            r_sec_tick <= w_sec;
            if (w_sec) r_time <= f_next(r_time);

            if (w_base && r_pulse != 8'd0) r_pulse <= r_pulse - 8'd1;
            if (w_sec && r_iv_run) begin
                if (w_iv_hit) begin
                    r_iv_cnt <= 6'd0;
                    r_pulse  <= 8'd128;
                end else begin
                    r_iv_cnt <= r_iv_cnt + 6'd1;
                end
            end

            // Data passes through cmd_sr first, so the last nibble is the command.
            if (w_shift) begin
                r_cmd_sr <= {r_din_s2, r_cmd_sr[3:1]};
                if (r_cmd == CMD_SHIFT)
                    r_shift_sr <= {r_cmd_sr[0], r_shift_sr[39:1]};
            end

            // Command execution overrides the tick updates above.
            if (w_stb_rise) begin
                r_cmd <= r_cmd_sr;
                case (r_cmd_sr)
                    CMD_SET: begin
                        r_time  <= r_shift_sr;
                        r_presc <= 13'd0;
                    end
                    CMD_READ: r_shift_sr <= r_time;
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        r_iv_mode <= 1'b0;
                        r_tp_sel  <= r_cmd_sr[1:0];
                        r_iv_run  <= 1'b0;
                        r_pulse   <= 8'd0;
                    end
                    4'h8, 4'h9, 4'hA, 4'hB: begin
                        r_iv_mode <= 1'b1;
                        r_iv_n    <= r_cmd_sr[1:0];
                        r_iv_cnt  <= 6'd0;
                        r_iv_run  <= 1'b1;
                        r_pulse   <= 8'd0;
                    end
                    CMD_IVCLR: begin
                        r_iv_cnt <= 6'd0;
                        r_pulse  <= 8'd0;
                    end
                    CMD_IVRUN: r_iv_run <= 1'b1;
                    CMD_IVSTP: begin
                        r_iv_mode <= 1'b1;
                        r_iv_run  <= 1'b0;
                        r_pulse   <= 8'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_upd4990.sv
// Self-checking bench for rtc_upd4990 with CLK_DIV = 1.
// Reference calendar is plain integer seconds-of-day arithmetic.
module tb_rtc_upd4990;

    localparam logic [39:0] INIT = 40'h1_0_01_00_00_00;

    logic clk = 1'b0;
    logic nRESET, rclk, din, stb;
    logic dout, tp, sec_tick;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    rtc_upd4990 #(
        .CLK_DIV  (1),
        .INIT_TIME(INIT)
    ) u_dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .RTC_CLK   (rclk),
        .RTC_DIN   (din),
        .RTC_STROBE(stb),
        .RTC_DOUT  (dout),
        .RTC_TP    (tp),
        .SEC_TICK  (sec_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [39:0] got,
                         input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic int mlen(input int mo);
        if (mo == 2) return 29;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic int unbcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [39:0] pack(input int mo, input int wd,
        input int d, input int h, input int mi, input int s);
        return {4'(mo), 4'(wd), bcd(d), bcd(h), bcd(mi), bcd(s)};
    endfunction

    function automatic logic [39:0] ref_next(input logic [39:0] t);
        int mo, wd, d, secs;
        mo   = int'(t[39:36]);
        wd   = int'(t[35:32]);
        d    = unbcd(t[31:24]);
        secs = unbcd(t[23:16]) * 3600 + unbcd(t[15:8]) * 60
             + unbcd(t[7:0]) + 1;
        if (secs == 86400) begin
            secs = 0;
            wd   = (wd + 1) % 7;
            d    = d + 1;
            if (d > mlen(mo)) begin
                d  = 1;
                mo = mo % 12 + 1;
            end
        end
        return pack(mo, wd, d, secs / 3600, (secs / 60) % 60, secs % 60);
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return dout;
            1:       return tp;
            default: return sec_tick;
        endcase
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = b;
        wait_n(4);
        rclk = 1'b1;
        wait_n(4);
        rclk = 1'b0;
        wait_n(4);
    endtask

    task automatic send_bits(input logic [39:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic strobe();
        stb = 1'b1;
        wait_n(4);
        stb = 1'b0;
        wait_n(4);
    endtask

    task automatic send_cmd(input logic [3:0] c);
        send_bits({36'd0, c}, 4);
        strobe();
    endtask

    task automatic set_time(input logic [39:0] v);
        send_cmd(4'h1);
        send_bits(v, 40);
        send_cmd(4'h2);
    endtask

    task automatic shift_out(output logic [39:0] v);
        send_cmd(4'h1);
        for (int i = 0; i < 40; i++) begin
            v[i] = dout;
            send_bit(1'b0);
        end
    endtask

    task automatic read_time(output logic [39:0] v);
        send_cmd(4'h3);
        shift_out(v);
    endtask

    task automatic wait_for(input string tag, input int w, input logic val,
                            input int limit, output int n);
        n = 0;
        while (sig(w) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 40'(sig(w)), 40'(val));
    endtask

    task automatic run_len(input int w, input int limit, output int n);
        logic v0;
        v0 = sig(w);
        n  = 0;
        while (sig(w) === v0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_low(input int cycles, output int lo);
        lo = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tp == 1'b0) lo++;
        end
    endtask

    task automatic cal_test(input string tag, input logic [39:0] v);
        logic [39:0] got;
        int          n;
        set_time(v);
        wait_for({tag, "_tick"}, 2, 1'b1, 9000, n);
        read_time(got);
        check(tag, got, ref_next(v));
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [39:0] v, got;
        int          n, lo, c0, mo, d;

        nRESET = 1'b0;
        rclk   = 1'b0;
        din    = 1'b0;
        stb    = 1'b0;
        wait_n(5);
        check("rst_dout", 40'(dout), 40'd0);
        check("rst_tp", 40'(tp), 40'd1);
        check("rst_sec_tick", 40'(sec_tick), 40'd0);
        nRESET = 1'b1;

        wait_for("hz1_rise", 0, 1'b1, 9000, n);
        check("hz1_rise_at", 40'(n), 40'd4096);
        run_len(0, 9000, n);
        check("hz1_high_len", 40'(n), 40'd4096);
        check("sec_tick_at_wrap", 40'(sec_tick), 40'd1);
        wait_n(1);
        check("sec_tick_1clk", 40'(sec_tick), 40'd0);

        cal_test("carry_to_day", 40'h3_2_15_23_59_59);
        cal_test("feb29_roll", 40'h2_6_29_23_59_59);
        cal_test("dec31_roll", 40'hC_3_31_23_59_59);

        for (int k = 0; k < 3; k++) begin
            mo = int'($urandom_range(12, 1));
            d  = int'($urandom_range(mlen(mo), 1));
            v  = pack(mo, int'($urandom_range(6, 0)), d,
                      int'($urandom_range(23, 0)), int'($urandom_range(59, 0)),
                      int'($urandom_range(59, 0)));
            set_time(v);
            read_time(got);
            check($sformatf("rand_rdback%0d", k), got, v);
        end

        v = 40'h1_0_01_00_00_59;
        send_cmd(4'h1);
        send_bits(v, 40);
        send_bits(40'h2, 4);
        c0 = cyc;
        stb = 1'b1;
        wait_n(4);
        stb = 1'b0;
        wait_n(4);
        send_bits(40'h3, 4);
        while (cyc < c0 + 8192) @(negedge clk);
        stb = 1'b1;
        wait_n(3);
        check("rd_tick_align", 40'(sec_tick), 40'd1);
        wait_n(1);
        stb = 1'b0;
        wait_n(4);
        shift_out(got);
        check("rd_on_tick", got, v);
        read_time(got);
        check("live_after_tick", got, ref_next(v));

        send_cmd(4'h5);
        wait_for("tp5_hi", 1, 1'b1, 100, n);
        wait_for("tp5_lo", 1, 1'b0, 100, n);
        run_len(1, 100, n);
        check("tp5_low_len", 40'(n), 40'd16);
        run_len(1, 100, n);
        check("tp5_high_len", 40'(n), 40'd16);

        send_cmd(4'h8);
        wait_for("iv_pulse", 1, 1'b0, 9000, n);
        check("iv_at_tick", 40'(sec_tick), 40'd1);
        run_len(1, 300, n);
        check("iv_low_len", 40'(n), 40'd128);
        send_cmd(4'hE);
        count_low(8300, lo);
        check("iv_stop_held", 40'(lo), 40'd0);

        send_bits(40'h4, 4);
        din = 1'b1;
        wait_n(4);
        rclk = 1'b1;
        stb  = 1'b1;
        wait_n(4);
        rclk = 1'b0;
        wait_n(4);
        stb = 1'b0;
        wait_n(4);
        count_low(200, lo);
        check("sim_strobe_exec", 40'(lo > 0), 40'd1);
        strobe();
        count_low(200, lo);
        check("sim_cmd_kept", 40'(lo > 0), 40'd1);

        send_cmd(4'h1);
        send_bits(40'($urandom()) | 40'h1, 20);
        din  = 1'b1;
        rclk = 1'b1;
        wait_n(1);
        nRESET = 1'b0;
        wait_n(3);
        check("midrst_dout", 40'(dout), 40'd0);
        check("midrst_tp", 40'(tp), 40'd1);
        rclk = 1'b0;
        din  = 1'b0;
        nRESET = 1'b1;
        wait_n(4);
        send_cmd(4'h1);
        check("midrst_sr_clr", 40'(dout), 40'd0);
        read_time(got);
        check("midrst_time", got, INIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
